// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// master = the bridge side, slave = the command source / APB peripheral side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              busy;

    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: one valid/ready command -> one APB transfer -> one response (APB_MASTER_TIMEOUT_EN adds an ACCESS wait limit).
// Latency: response 3 cycles after accept with a zero-wait slave, +1 per PREADY-low cycle; misaligned commands respond after 1.
// Backpressure: single outstanding command; cmd_ready only in IDLE, response held until rsp_ready.
module apb_master_bridge #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              out_of_reset_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              misaligned;
    logic              complete;
    logic              timeout_hit;

    logic              cmd_ready_c;
    logic              rsp_valid_c;
    logic              busy_c;
    logic              psel_c;
    logic              penable_c;
    logic [31:0]       pwdata_c;

    assign misaligned = (bus.cmd_addr[1:0] != 2'b00);
    assign accept     = cmd_ready_c && bus.cmd_valid;
    assign complete   = (state_q == ST_ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt_q;

    // Counts PREADY-low ACCESS cycles; PREADY on the limit cycle still completes normally.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ST_ACCESS) && !bus.PREADY) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end

    assign timeout_hit = (state_q == ST_ACCESS) && !bus.PREADY && (wait_cnt_q == WAIT_LAST);
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q        <= ST_IDLE;
            out_of_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_of_reset_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b1;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        pwdata_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Held low until the first clock after reset release.
                busy_c      = 1'b0;
                cmd_ready_c = out_of_reset_q;
                if (out_of_reset_q && bus.cmd_valid) begin
                    state_d = misaligned ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_c   = 1'b1;
                pwdata_c = pwrite_q ? wdata_q : '0;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                pwdata_c  = pwrite_q ? wdata_q : '0;
                if (complete || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PADDR/PWRITE only move for commands that really reach the bus.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wdata_q <= bus.cmd_wdata;
                if (misaligned) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    paddr_q  <= {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    pwrite_q <= bus.cmd_write;
                end
            end
            if (complete) begin
                rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                err_q   <= bus.PSLVERR;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_c;
    assign bus.PSEL      = psel_c;
    assign bus.PENABLE   = penable_c;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_c;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboarded bench for apb_master_bridge: randomized commands, a wait-state APB slave model,
// directed latency/error/misalignment/reset/timeout scenarios.
module tb_apb_master_bridge;

    localparam int ADDR_W      = 12;
    localparam int TIMEOUT_CYC = 16;

    logic PCLK = 1'b0;
    logic PRESETn;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    apb_master_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc_cyc;
    } exp_t;

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int unsigned       waits;
        logic              err;
    } job_t;

    exp_t        sb_q[$];
    job_t        job_q[$];
    logic [31:0] ref_mem   [0:15];
    logic [31:0] slave_mem [0:15];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          hold_cnt = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- APB slave model ----------------
    job_t              cur;
    bit                active = 0;
    int unsigned       left   = 0;
    logic [ADDR_W-1:0] last_addr  = '0;
    logic              last_write = 1'b0;

    task automatic drive_ready();
        bus.PREADY  = 1'b1;
        bus.PSLVERR = cur.err;
        if (cur.err)        bus.PRDATA = 32'h0;
        else if (cur.write) bus.PRDATA = $urandom;
        else                bus.PRDATA = slave_mem[cur.addr[5:2]];
        if (cur.write && !cur.err) slave_mem[cur.addr[5:2]] = cur.wdata;
    endtask

    task automatic drive_wait();
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
    endtask

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'h0;
            active      = 0;
            last_addr   = '0;
            last_write  = 1'b0;
        end else if (bus.PSEL && !bus.PENABLE) begin
            if (job_q.size() == 0) begin
                check("spurious_psel", 32'(bus.PSEL), 32'h0);
                active = 0;
            end else begin
                cur    = job_q.pop_front();
                active = 1;
                left   = cur.waits;
                check("setup_paddr",  32'(bus.PADDR),  32'(cur.addr));
                check("setup_pwrite", 32'(bus.PWRITE), 32'(cur.write));
                check("setup_pwdata", bus.PWDATA, cur.write ? cur.wdata : 32'h0);
                last_addr  = cur.addr;
                last_write = cur.write;
                drive_wait();
            end
        end else if (bus.PSEL && bus.PENABLE && active) begin
            check("access_paddr",  32'(bus.PADDR),  32'(cur.addr));
            check("access_pwrite", 32'(bus.PWRITE), 32'(cur.write));
            check("access_pwdata", bus.PWDATA, cur.write ? cur.wdata : 32'h0);
            if (left == 0) begin
                drive_ready();
            end else begin
                left--;
                drive_wait();
            end
        end else begin
            active = 0;
            drive_wait();
            if (!bus.PSEL) begin
                check("idle_pwdata", bus.PWDATA, 32'h0);
                check("idle_paddr_hold", 32'(bus.PADDR), 32'(last_addr));
                check("idle_pwrite_hold", 32'(bus.PWRITE), 32'(last_write));
            end
        end
    end

    // ---------------- response monitor ----------------
    bit          seen     = 0;
    bit          held     = 0;
    bit          after_hs = 0;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESETn) begin
            bus.rsp_ready = 1'b0;
            seen     = 0;
            held     = 0;
            after_hs = 0;
        end else begin
            if (after_hs) begin
                check("rsp_single_cycle", 32'(bus.rsp_valid), 32'h0);
                check("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'h1);
                after_hs = 0;
            end
            if (bus.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                    bus.rsp_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        check("latency", cyc - sb_q[0].acc_cyc, sb_q[0].lat);
                        seen = 1;
                    end
                    if (held) begin
                        check("rsp_rdata_stable", bus.rsp_rdata, held_rdata);
                        check("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
                    end
                    check("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'h0);
                    if (hold_cnt > 0) begin
                        bus.rsp_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (bus.rsp_ready) begin
                        e = sb_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        seen     = 0;
                        held     = 0;
                        after_hs = 1;
                    end else begin
                        held       = 1;
                        held_rdata = bus.rsp_rdata;
                        held_err   = bus.rsp_err;
                    end
                end
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input int unsigned waits, input logic serr, input bit score);
        exp_t e;
        job_t j;
        bit   timed_out;
        int   n = 0;
        @(negedge PCLK);
        while (!bus.cmd_ready && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_ready_wait", 32'(bus.cmd_ready), 32'h1);
            return;
        end
        if (a[1:0] != 2'b00) begin
            e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
        end else begin
            timed_out = 0;
`ifdef APB_MASTER_TIMEOUT_EN
            timed_out = (waits >= TIMEOUT_CYC);
`endif
            j.write = w; j.addr = a; j.wdata = d; j.waits = waits; j.err = serr;
            job_q.push_back(j);
            e.rdata = 32'h0;
            e.err   = 1'b0;
            e.lat   = 3 + waits;
            if (timed_out) begin
                e.err = 1'b1;
                e.lat = 2 + TIMEOUT_CYC;
            end else if (serr) begin
                e.err = 1'b1;
            end else if (w) begin
                ref_mem[a[5:2]] = d;
            end else begin
                e.rdata = ref_mem[a[5:2]];
            end
        end
        e.acc_cyc = cyc;
        if (score) sb_q.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic wait_access();
        int n = 0;
        while (!(bus.PSEL && bus.PENABLE) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("reach_access", 32'(bus.PSEL && bus.PENABLE), 32'h1);
    endtask

    task automatic reset_mid_access();
        wait_access();
        repeat (4) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_psel", 32'(bus.PSEL), 32'h0);
        check("rst_penable", 32'(bus.PENABLE), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        sb_q.delete();
        job_q.delete();
        @(negedge PCLK);
        @(negedge PCLK);
        #3 PRESETn = 1'b1;
        @(negedge PCLK);
        check("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]   = $urandom;
            slave_mem[i] = ref_mem[i];
        end

        #12;
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_psel", 32'(bus.PSEL), 32'h0);
        check("reset_penable", 32'(bus.PENABLE), 32'h0);
        check("reset_paddr", 32'(bus.PADDR), 32'h0);
        check("reset_pwrite", 32'(bus.PWRITE), 32'h0);
        check("reset_pwdata", bus.PWDATA, 32'h0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        #11 PRESETn = 1'b1;

        // zero-wait write, 3-wait read, slave error, misaligned with held response
        issue(1'b1, 12'h004, 32'h0000_00A5, 0, 1'b0, 1);
        issue(1'b1, 12'h000, 32'h0000_00FF, 0, 1'b0, 1);
        issue(1'b0, 12'h000, 32'h0, 3, 1'b0, 1);
        issue(1'b1, 12'h008, 32'h1234_5678, 2, 1'b1, 1);
        issue(1'b0, 12'h008, 32'h0, 1, 1'b0, 1);
        hold_cnt = 5;
        issue(1'b1, 12'h006, 32'hDEAD_BEEF, 0, 1'b0, 1);
        drain();

        // reset while the slave is stalling
        issue(1'b0, 12'h00C, 32'h0, 40, 1'b0, 0);
        reset_mid_access();
        issue(1'b0, 12'h004, 32'h0, 0, 1'b0, 1);
        drain();

        // permanently stalled slave
`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 12'h010, 32'h0, 200, 1'b0, 1);
        drain();
`else
        issue(1'b0, 12'h010, 32'h0, 1000, 1'b0, 0);
        wait_access();
        repeat (100) @(negedge PCLK);
        check("stall_psel", 32'(bus.PSEL), 32'h1);
        check("stall_penable", 32'(bus.PENABLE), 32'h1);
        check("stall_busy", 32'(bus.busy), 32'h1);
        reset_mid_access();
`endif

        for (int t = 0; t < 150; t++) begin
            a = ADDR_W'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + ADDR_W'($urandom_range(1, 3));
            issue(1'($urandom_range(0, 1)), a, $urandom,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2),
                  ($urandom_range(0, 5) == 0), 1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
